irq_ctrl: RTL

IRQ_CTRL -- requirements
Module: irq_ctrl

---
 rtl/irq_ctrl_if.sv | 26 ++
 rtl/irq_ctrl.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/irq_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : irq_ctrl_if                                                   |
// | Brief    : CPU-side bus and interrupt handshake for irq_ctrl             |
// | Revision : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
interface irq_ctrl_if;
   logic [31:0] adr;
   logic [31:0] writedata;
   logic        memwrite;
   logic [31:0] readdata;
   logic        hit;
   logic        irq;
   logic        iack;

   modport master (
      output adr, writedata, memwrite, iack,
      input  readdata, hit, irq
   );

   modport slave (
      input  adr, writedata, memwrite, iack,
      output readdata, hit, irq
   );
endinterface
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : irq_ctrl                                                      |
// | Brief    : Edge-triggered interrupt controller, lowest-index priority,   |
// |            memory-mapped PENDING/ENABLE/ID/EOI registers                 |
// | Revision : 1.0 - initial release                                         |
// ---------------------------------------------------------------------------
module irq_ctrl #(
   parameter int          NSRC = 8,
   parameter logic [31:0] BASE = 32'hFFFF_FF00
) (
   input  wire logic            clk,
   input  wire logic            reset,
   input  wire logic [NSRC-1:0] src,
   irq_ctrl_if.slave            bus
);

   localparam logic [1:0] c_REG_PENDING = 2'd0;
   localparam logic [1:0] c_REG_ENABLE  = 2'd1;
   localparam logic [1:0] c_REG_ID      = 2'd2;
   localparam logic [1:0] c_REG_EOI     = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_REQ     = 2'd1,
      S_SERVICE = 2'd2
   } state_t;

   state_t          r_state;
   logic            r_irq;
   logic [NSRC-1:0] r_src_q;
   logic [NSRC-1:0] r_pending;
   logic [NSRC-1:0] r_enable;
   logic            r_id_valid;
   logic [3:0]      r_id;

   logic            w_hit;
   logic            w_wr;
   logic [1:0]      w_reg;
   logic [NSRC-1:0] w_rise;
   logic [NSRC-1:0] w_active;
   logic            w_req;
   logic [3:0]      w_winner;
   logic [NSRC-1:0] w_win_mask;
   logic            w_take;
   logic [NSRC-1:0] w_clr;
   logic            w_unused;

   assign w_hit    = (bus.adr[31:4] == BASE[31:4]);
   assign w_wr     = bus.memwrite & w_hit;
   assign w_reg    = bus.adr[3:2];
   assign w_rise   = src & ~r_src_q;
   assign w_active = r_pending & r_enable;
   assign w_req    = |w_active;
   // iack is only honoured while a request is outstanding in REQ
   assign w_take   = (r_state == S_REQ) & bus.iack & w_req;
   // byte-lane and upper data bits carry no meaning for this block
   assign w_unused = ^{bus.adr[1:0], bus.writedata[31:NSRC]};

   // lowest-index active source wins; mask is its one-hot form
   always_comb begin
      w_winner   = 4'd0;
      w_win_mask = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (w_active[i]) begin
            w_winner   = 4'(i);
            w_win_mask = '0;
            w_win_mask[i] = 1'b1;
         end
      end
   end

   // bits leaving PENDING this cycle: software W1C plus the acknowledged winner
   always_comb begin
      w_clr = '0;
      if (w_wr && (w_reg == c_REG_PENDING)) w_clr = bus.writedata[NSRC-1:0];
      if (w_take)                           w_clr = w_clr | w_win_mask;
   end

   // edge capture, pending/enable storage; a new edge beats any clear
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_src_q   <= src;
         r_pending <= '0;
         r_enable  <= '0;
      end else begin
         r_src_q   <= src;
         r_pending <= (r_pending & ~w_clr) | w_rise;
         if (w_wr && (w_reg == c_REG_ENABLE)) r_enable <= bus.writedata[NSRC-1:0];
      end
   end

   // request/service sequencing with registered irq and in-service ID
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_irq      <= 1'b0;
         r_id_valid <= 1'b0;
         r_id       <= 4'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_state <= S_REQ;
                  r_irq   <= 1'b1;
               end
            end
            S_REQ: begin
               if (!w_req) begin
                  r_state <= S_IDLE;
                  r_irq   <= 1'b0;
               end else if (bus.iack) begin
                  r_state    <= S_SERVICE;
                  r_irq      <= 1'b0;
                  r_id_valid <= 1'b1;
                  r_id       <= w_winner;
               end
            end
            S_SERVICE: begin
               if (w_wr && (w_reg == c_REG_EOI)) begin
                  r_state    <= S_IDLE;
                  r_id_valid <= 1'b0;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_irq   <= 1'b0;
            end
         endcase
      end
   end

   // side-effect-free register read mux, zero outside the decoded window
   always_comb begin
      bus.readdata = 32'd0;
      if (w_hit) begin
         case (w_reg)
            c_REG_PENDING: bus.readdata = 32'(r_pending);
            c_REG_ENABLE:  bus.readdata = 32'(r_enable);
            c_REG_ID:      bus.readdata = {r_id_valid, 27'd0, r_id};
            default:       bus.readdata = 32'd0;
         endcase
      end
   end

   assign bus.hit = w_hit;
   assign bus.irq = r_irq;

endmodule
`default_nettype wire
